// File: rtl/seq_adder.sv
// seq_adder: iterative adder/subtractor that consumes CHUNK bits per clock,
// carrying between cycles, behind a start/busy/done handshake.
// Computes a + (b ^ {WIDTH{subEn}}) + subEn with the carry out of the MSB.
// Optional feature macro: SEQ_ADDER_FLAGS_EN adds registered ovf/zero flags.
module seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subEn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SEQ_ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;

    logic [CHUNK:0]         chunk_sum_s;
    logic [WIDTH+CHUNK-1:0] shift_s;
    logic [WIDTH-1:0]       result_next_s;
    logic                   accept_s;
    logic                   last_s;

`ifdef SEQ_ADDER_FLAGS_EN
    logic a_sign_q, a_sign_d;
    logic b_sign_q, b_sign_d;
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;
`endif

    // Chunk adder and handshake qualifiers shared by FSM and datapath.
    always_comb begin
        chunk_sum_s   = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};
        // New sum chunk enters at the MSB end while the result moves right.
        shift_s       = {chunk_sum_s[CHUNK-1:0], result_q};
        result_next_s = shift_s[WIDTH+CHUNK-1:CHUNK];
        last_s        = (cnt_q == CNT_LAST);
        if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // State register, handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SEQ_ADDER_FLAGS_EN
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SEQ_ADDER_FLAGS_EN
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
`endif
        end
    end

    // Next-state logic: DONE accepts a new start just like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they register cleanly.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            S_RUN: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture on accept, chunk-serial add while running.
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SEQ_ADDER_FLAGS_EN
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    opa_d    = a;
                    opb_d    = b ^ {WIDTH{subEn}};
                    carry_d  = subEn;
                    cnt_d    = '0;
`ifdef SEQ_ADDER_FLAGS_EN
                    a_sign_d = a[WIDTH-1];
                    b_sign_d = b[WIDTH-1] ^ subEn;
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RUN: begin
                opa_d    = opa_q >> CHUNK;
                opb_d    = opb_q >> CHUNK;
                carry_d  = chunk_sum_s[CHUNK];
                cnt_d    = cnt_q + CNT_W'(1);
                result_d = result_next_s;
                if (last_s) begin
                    cout_d = chunk_sum_s[CHUNK];
`ifdef SEQ_ADDER_FLAGS_EN
                    ovf_d  = (a_sign_q == b_sign_q) && (result_next_s[WIDTH-1] != a_sign_q);
                    zero_d = (result_next_s == {WIDTH{1'b0}});
`endif
                end else begin
                    cout_d = cout_q;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SEQ_ADDER_FLAGS_EN
    assign ovf    = ovf_q;
    assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_seq_adder.sv
// Testbench for seq_adder: a 32/8 instance and a 16/16 instance, checked
// against an integer-arithmetic reference model. Flag checks are active when
// SEQ_ADDER_FLAGS_EN is defined.
module tb_seq_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = 32'd0, b32 = 32'd0;
    logic        busy32, done32, cout32;
    logic [31:0] res32;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = 16'd0, b16 = 16'd0;
    logic        busy16, done16, cout16;
    logic [15:0] res16;

`ifdef SEQ_ADDER_FLAGS_EN
    logic ovf32, zero32, ovf16, zero16;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .subEn(sub32),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32)
`ifdef SEQ_ADDER_FLAGS_EN
        , .ovf(ovf32), .zero(zero32)
`endif
    );

    seq_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .subEn(sub16),
        .busy(busy16), .done(done16), .result(res16), .cout(cout16)
`ifdef SEQ_ADDER_FLAGS_EN
        , .ovf(ovf16), .zero(zero16)
`endif
    );

    // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
    function automatic void ref_model(input int w, input longint ua, input longint ub,
                                      input bit sub, output longint res, output bit co,
                                      output bit ov, output bit ze);
        longint m, sa, sb, t, st;
        m  = longint'(1) << w;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!sub) begin
            t   = ua + ub;
            co  = (t >= m);
            res = t % m;
            st  = sa + sb;
        end else begin
            co  = (ua >= ub);
            res = (ua - ub + m) % m;
            st  = sa - sb;
        end
        ov = (st >= m / 2) || (st < -(m / 2));
        ze = (res == 0);
    endfunction

    // Wait (bounded) for done on the 32-bit instance; lat = -1 on timeout.
    task automatic wait_done32(output logic [31:0] ores, output logic oco, output logic oov,
                               output logic oze, output int lat, output int nbusy);
        lat = -1; nbusy = 0; ores = '0; oco = 1'b0; oov = 1'b0; oze = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (busy32 === 1'b1) nbusy++;
            if (done32 === 1'b1) begin
                lat = k; ores = res32; oco = cout32;
`ifdef SEQ_ADDER_FLAGS_EN
                oov = ovf32; oze = zero32;
`endif
                break;
            end
        end
    endtask

    task automatic do_op32(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                           output logic [31:0] ores, output logic oco, output logic oov,
                           output logic oze, output int lat, output int nbusy);
        @(negedge clk);
        a32 = ia; b32 = ib; sub32 = isub; start32 = 1'b1;
        wait_done32(ores, oco, oov, oze, lat, nbusy);
    endtask

    task automatic do_op16(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                           output logic [15:0] ores, output logic oco, output logic oov,
                           output logic oze, output int lat);
        @(negedge clk);
        a16 = ia; b16 = ib; sub16 = isub; start16 = 1'b1;
        lat = -1; ores = '0; oco = 1'b0; oov = 1'b0; oze = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16 === 1'b1) begin
                lat = k; ores = res16; oco = cout16;
`ifdef SEQ_ADDER_FLAGS_EN
                oov = ovf16; oze = zero16;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy32, done32, cout32} !== 3'b000) begin n_fail++;
            $display("FAIL reset_ctl32: busy/done/cout=%b expected 000", {busy32, done32, cout32}); end
        n_cmp++; if (res32 !== 32'd0) begin n_fail++;
            $display("FAIL reset_res32: got %h expected 0", res32); end
        n_cmp++; if ({busy16, done16, cout16, res16} !== 19'd0) begin n_fail++;
            $display("FAIL reset16: got %h expected 0", {busy16, done16, cout16, res16}); end
`ifdef SEQ_ADDER_FLAGS_EN
        n_cmp++; if ({ovf32, zero32, ovf16, zero16} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {ovf32, zero32, ovf16, zero16}); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        logic [31:0] r; logic c, o, z; int lat, nb;
        do_op32(32'd5, 32'd3, 1'b0, r, c, o, z, lat, nb);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_cmp++; if (nb !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", nb); end
        n_cmp++; if (r !== 32'd8 || c !== 1'b0) begin n_fail++;
            $display("FAIL basic_result: got %h/%b expected 00000008/0", r, c); end
        repeat (2) @(negedge clk);
        n_cmp++; if (res32 !== 32'd8 || done32 !== 1'b0 || busy32 !== 1'b0) begin n_fail++;
            $display("FAIL basic_hold: res=%h done=%b busy=%b expected 00000008/0/0", res32, done32, busy32); end
    endtask

    task automatic test_carry_ovf();
        logic [31:0] r; logic c, o, z; int lat, nb;
        do_op32(32'hFFFF_FFFF, 32'd1, 1'b0, r, c, o, z, lat, nb);
        n_cmp++; if (r !== 32'd0 || c !== 1'b1) begin n_fail++;
            $display("FAIL carry_wrap: got %h/%b expected 00000000/1", r, c); end
`ifdef SEQ_ADDER_FLAGS_EN
        n_cmp++; if (z !== 1'b1 || o !== 1'b0) begin n_fail++;
            $display("FAIL carry_flags: zero/ovf=%b%b expected 10", z, o); end
`endif
        do_op32(32'h7FFF_FFFF, 32'd1, 1'b0, r, c, o, z, lat, nb);
        n_cmp++; if (r !== 32'h8000_0000 || c !== 1'b0) begin n_fail++;
            $display("FAIL ovf_sum: got %h/%b expected 80000000/0", r, c); end
`ifdef SEQ_ADDER_FLAGS_EN
        n_cmp++; if (o !== 1'b1 || z !== 1'b0) begin n_fail++;
            $display("FAIL ovf_flags: ovf/zero=%b%b expected 10", o, z); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic c, o, z; int lat, nb;
        do_op32(32'd3, 32'd5, 1'b1, r, c, o, z, lat, nb);
        n_cmp++; if (r !== 32'hFFFF_FFFE || c !== 1'b0) begin n_fail++;
            $display("FAIL sub_borrow: got %h/%b expected fffffffe/0", r, c); end
        // still in the DONE cycle: issue the next operation immediately
        a32 = 32'd5; b32 = 32'd3; sub32 = 1'b1; start32 = 1'b1;
        wait_done32(r, c, o, z, lat, nb);
        n_cmp++; if (lat !== 5 || nb !== 4) begin n_fail++;
            $display("FAIL b2b_timing: latency %0d busy %0d expected 5/4", lat, nb); end
        n_cmp++; if (r !== 32'd2 || c !== 1'b1) begin n_fail++;
            $display("FAIL b2b_result: got %h/%b expected 00000002/1", r, c); end
    endtask

    task automatic test_start_held();
        int first = -1, second = -1;
        logic [31:0] r1 = '0, r2 = '0;
        @(negedge clk);
        a32 = 32'd1; b32 = 32'd1; sub32 = 1'b0; start32 = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            a32 = 32'd100; b32 = 32'd100;
            if (done32 === 1'b1) begin
                if (first < 0) begin
                    first = k; r1 = res32;
                end else begin
                    second = k; r2 = res32; start32 = 1'b0;
                    break;
                end
            end
        end
        start32 = 1'b0;
        n_cmp++; if (first !== 5 || r1 !== 32'd2) begin n_fail++;
            $display("FAIL held_first: cycle %0d result %h expected 5/00000002", first, r1); end
        n_cmp++; if (second !== 10 || r2 !== 32'd200) begin n_fail++;
            $display("FAIL held_second: cycle %0d result %h expected 10/000000c8", second, r2); end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        @(negedge clk);
        a32 = 32'd7; b32 = 32'd9; sub32 = 1'b0; start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;   // cycle 1
        @(negedge clk); rst = 1'b1;       // cycle 2
        @(negedge clk);
        n_cmp++; if ({busy32, done32, cout32} !== 3'b000 || res32 !== 32'd0) begin n_fail++;
            $display("FAIL abort_state: busy/done/cout=%b res=%h expected 000/0", {busy32, done32, cout32}, res32); end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done32 === 1'b1 || busy32 === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++;
            $display("FAIL abort_no_done: %0d active cycles expected 0", pulses); end
    endtask

    task automatic test_reset_start_same();
        int active = 0;
        @(negedge clk);
        rst = 1'b1; start32 = 1'b1; a32 = 32'd11; b32 = 32'd22; sub32 = 1'b0;
        @(negedge clk);
        rst = 1'b0; start32 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (busy32 === 1'b1 || done32 === 1'b1) active++;
            @(negedge clk);
        end
        n_cmp++; if (active !== 0) begin n_fail++;
            $display("FAIL rst_start_same: %0d active cycles expected 0", active); end
    endtask

    task automatic test_chunk_eq_width();
        logic [15:0] r; logic c, o, z; int lat;
        do_op16(16'h8000, 16'h8000, 1'b0, r, c, o, z, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL w16_latency: got %0d expected 2", lat); end
        n_cmp++; if (r !== 16'd0 || c !== 1'b1) begin n_fail++;
            $display("FAIL w16_result: got %h/%b expected 0000/1", r, c); end
`ifdef SEQ_ADDER_FLAGS_EN
        n_cmp++; if (o !== 1'b1 || z !== 1'b1) begin n_fail++;
            $display("FAIL w16_flags: ovf/zero=%b%b expected 11", o, z); end
`endif
    endtask

    task automatic test_random32();
        logic [31:0] ra, rb, r; logic rs, c, o, z; int lat, nb;
        longint er; bit ec, eo, ez;
        for (int k = 0; k < 32; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (k % 8 == 0) begin rb = ra; rs = 1'b1; end
            if (k % 8 == 4) begin ra = 32'h8000_0000 ^ ($urandom & 32'hF); end
            do_op32(ra, rb, rs, r, c, o, z, lat, nb);
            ref_model(32, longint'(ra), longint'(rb), rs, er, ec, eo, ez);
            n_cmp++; if (lat !== 5 || r !== 32'(er) || c !== ec) begin n_fail++;
                $display("FAIL rand32: a=%h b=%h sub=%b got %h/%b lat %0d expected %h/%b lat 5",
                         ra, rb, rs, r, c, lat, 32'(er), ec); end
`ifdef SEQ_ADDER_FLAGS_EN
            n_cmp++; if (o !== eo || z !== ez) begin n_fail++;
                $display("FAIL rand32_flags: a=%h b=%h sub=%b ovf/zero=%b%b expected %b%b",
                         ra, rb, rs, o, z, eo, ez); end
`endif
        end
    endtask

    task automatic test_random16();
        logic [15:0] ra, rb, r; logic rs, c, o, z; int lat;
        longint er; bit ec, eo, ez;
        for (int k = 0; k < 32; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
            if (k % 8 == 0) begin rb = ra; rs = 1'b1; end
            do_op16(ra, rb, rs, r, c, o, z, lat);
            ref_model(16, longint'(ra), longint'(rb), rs, er, ec, eo, ez);
            n_cmp++; if (lat !== 2 || r !== 16'(er) || c !== ec) begin n_fail++;
                $display("FAIL rand16: a=%h b=%h sub=%b got %h/%b lat %0d expected %h/%b lat 2",
                         ra, rb, rs, r, c, lat, 16'(er), ec); end
`ifdef SEQ_ADDER_FLAGS_EN
            n_cmp++; if (o !== eo || z !== ez) begin n_fail++;
                $display("FAIL rand16_flags: a=%h b=%h sub=%b ovf/zero=%b%b expected %b%b",
                         ra, rb, rs, o, z, eo, ez); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_ovf();
        test_back_to_back();
        test_start_held();
        test_reset_abort();
        test_reset_start_same();
        test_chunk_eq_width();
        test_random32();
        test_random16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
